// File: rtl/register_file_pkg.sv
// Shared widths and word type for the register file slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package register_file_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDR_WIDTH_DEF = 2;
    localparam int DEPTH_DEF      = 2 ** ADDR_WIDTH_DEF;

    typedef logic [DATA_WIDTH_DEF-1:0] data_t;
    typedef logic [ADDR_WIDTH_DEF-1:0] addr_t;

endpackage

// File: rtl/register_file_if.sv
// Write port plus two read ports of the register file, bundled as one bus.
// Latency: writes land on the next rising clk edge; reads are combinational.
// Backpressure: none, every write and read is accepted immediately.
interface register_file_if #(
    parameter int DATA_WIDTH = register_file_pkg::DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = register_file_pkg::ADDR_WIDTH_DEF
);

    logic                  we;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [DATA_WIDTH-1:0] write_data;
    logic [ADDR_WIDTH-1:0] read_addr1;
    logic [ADDR_WIDTH-1:0] read_addr2;
    logic [DATA_WIDTH-1:0] read_data1;
    logic [DATA_WIDTH-1:0] read_data2;

    // Requester side: drives the write port and both read addresses.
    modport master (
        output we,
        output write_addr,
        output write_data,
        output read_addr1,
        output read_addr2,
        input  read_data1,
        input  read_data2
    );

    // Register file side: consumes requests, returns read data.
    modport slave (
        input  we,
        input  write_addr,
        input  write_data,
        input  read_addr1,
        input  read_addr2,
        output read_data1,
        output read_data2
    );

endinterface

// File: rtl/register_file_decoder.sv
// Turns write_addr + we into a one-hot per-register write-enable vector.
// Latency: purely combinational.
// Backpressure: none.
module register_file_decoder #(
    parameter int ADDR_WIDTH = register_file_pkg::ADDR_WIDTH_DEF,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    output logic [DEPTH-1:0]      wr_en
);

    // Addresses at or beyond DEPTH match no bit, so such writes fall away.
    always_comb begin
        wr_en = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_en[i] = we && (write_addr == ADDR_WIDTH'(i));
        end
    end

endmodule

// File: rtl/register_file.sv
// DEPTH x DATA_WIDTH register file, one write port and two independent read ports.
// Latency: write visible after the next rising clk; reads are zero-latency muxes, no bypass.
// Backpressure: none; asynchronous reset clears every register and blocks writes while high.
module register_file
    import register_file_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    register_file_if.slave bus
);

    logic [DEPTH-1:0]      wr_en;
    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];
    logic [DATA_WIDTH-1:0] read_data1;
    logic [DATA_WIDTH-1:0] read_data2;

    register_file_decoder #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_decoder (
        .we         (bus.we),
        .write_addr (bus.write_addr),
        .wr_en      (wr_en)
    );

    // Next state: only the register selected by the one-hot enable loads new data.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = wr_en[i] ? bus.write_data : regs_q[i];
        end
    end

    // Storage: async reset wins over any coincident write edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read muxes: straight from the flops, unmapped addresses read as zero.
    always_comb begin
        read_data1 = '0;
        read_data2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.read_addr1 == ADDR_WIDTH'(i)) begin
                read_data1 = regs_q[i];
            end
            if (bus.read_addr2 == ADDR_WIDTH'(i)) begin
                read_data2 = regs_q[i];
            end
        end
    end

    assign bus.read_data1 = read_data1;
    assign bus.read_data2 = read_data2;

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: full-depth instance plus a DEPTH=3 instance sharing stimulus.
// Latency: expects zero-latency reads and writes visible one edge later.
// Backpressure: n/a.
module tb_register_file;
    import register_file_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    register_file_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) bus  ();
    register_file_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) bus3 ();

    // The short instance sees exactly the same requests as the full one.
    assign bus3.we         = bus.we;
    assign bus3.write_addr = bus.write_addr;
    assign bus3.write_data = bus.write_data;
    assign bus3.read_addr1 = bus.read_addr1;
    assign bus3.read_addr2 = bus.read_addr2;

    register_file #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    register_file #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .DEPTH(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    int checks = 0;
    int passed = 0;

    // Reference model: plain array of the four register contents.
    data_t mem [4];

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mem[i] = 8'h00;
    endtask

    // Advance one rising edge, applying the write to the model, then settle.
    task automatic tick();
        @(posedge clk);
        if (rst === 1'b0 && bus.we === 1'b1) mem[bus.write_addr] = bus.write_data;
        #1;
    endtask

    // Observed output p: 0/1 full-depth ports, 2/3 the DEPTH=3 ports.
    function automatic data_t obs(int p);
        case (p)
            0:       return bus.read_data1;
            1:       return bus.read_data2;
            2:       return bus3.read_data1;
            default: return bus3.read_data2;
        endcase
    endfunction

    // Model read for output p at the current read addresses.
    function automatic data_t model_rd(int p);
        addr_t a;
        a = (p == 0 || p == 2) ? bus.read_addr1 : bus.read_addr2;
        if (p >= 2 && a == 2'd3) return 8'h00;
        return mem[a];
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.we = 1'b0; bus.write_addr = '0; bus.write_data = '0;
        model_reset();
        #2;
        for (int a = 0; a < 4; a++) begin
            bus.read_addr1 = addr_t'(a);
            bus.read_addr2 = addr_t'(3 - a);
            #1;
            for (int p = 0; p < 4; p++) begin
                checks++;
                if (obs(p) !== 8'h00) $display("FAIL reset_read addr=%0d port=%0d got=%h want=00", a, p, obs(p));
                else passed++;
            end
        end
    endtask

    task automatic test_write_read();
        data_t want [4];
        want = '{8'd4, 8'd12, 8'd4, 8'd12};
        @(negedge clk);
        rst = 1'b0;
        bus.we = 1'b1; bus.write_addr = 2'd0; bus.write_data = 8'd4;
        tick();
        bus.write_addr = 2'd1; bus.write_data = 8'd12;
        tick();
        bus.we = 1'b0; bus.read_addr1 = 2'd0; bus.read_addr2 = 2'd1;
        #1;
        for (int p = 0; p < 4; p++) begin
            checks++;
            if (obs(p) !== want[p]) $display("FAIL write_read port=%0d got=%h want=%h", p, obs(p), want[p]);
            else passed++;
        end
    endtask

    task automatic test_we_low();
        data_t want [4];
        bus.we = 1'b0; bus.write_addr = 2'd2; bus.write_data = 8'hFF;
        repeat (3) tick();
        bus.read_addr1 = 2'd2; bus.read_addr2 = 2'd0;
        #1;
        want = '{8'h00, 8'd4, 8'h00, 8'd4};
        for (int p = 0; p < 4; p++) begin
            checks++;
            if (obs(p) !== want[p]) $display("FAIL we_low_a port=%0d got=%h want=%h", p, obs(p), want[p]);
            else passed++;
        end
        bus.read_addr1 = 2'd1; bus.read_addr2 = 2'd2;
        #1;
        want = '{8'd12, 8'h00, 8'd12, 8'h00};
        for (int p = 0; p < 4; p++) begin
            checks++;
            if (obs(p) !== want[p]) $display("FAIL we_low_b port=%0d got=%h want=%h", p, obs(p), want[p]);
            else passed++;
        end
    endtask

    task automatic test_read_during_write();
        data_t want [4];
        @(negedge clk);
        bus.we = 1'b1; bus.write_addr = 2'd3; bus.write_data = 8'hA5;
        bus.read_addr1 = 2'd3; bus.read_addr2 = 2'd3;
        #1;
        for (int p = 0; p < 4; p++) begin
            checks++;
            if (obs(p) !== 8'h00) $display("FAIL rdw_before port=%0d got=%h want=00", p, obs(p));
            else passed++;
        end
        tick();
        bus.we = 1'b0;
        // Address 3 does not exist in the DEPTH=3 instance: write dropped, read zero.
        want = '{8'hA5, 8'hA5, 8'h00, 8'h00};
        for (int p = 0; p < 4; p++) begin
            checks++;
            if (obs(p) !== want[p]) $display("FAIL rdw_after port=%0d got=%h want=%h", p, obs(p), want[p]);
            else passed++;
        end
    endtask

    task automatic test_async_reset();
        data_t want [4];
        @(negedge clk);
        bus.we = 1'b1; bus.write_addr = 2'd2; bus.write_data = 8'h5A;
        tick();
        bus.we = 1'b0; bus.read_addr1 = 2'd2; bus.read_addr2 = 2'd3;
        #1;
        want = '{8'h5A, 8'hA5, 8'h5A, 8'h00};
        for (int p = 0; p < 4; p++) begin
            checks++;
            if (obs(p) !== want[p]) $display("FAIL pre_reset port=%0d got=%h want=%h", p, obs(p), want[p]);
            else passed++;
        end
        @(negedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        for (int p = 0; p < 4; p++) begin
            checks++;
            if (obs(p) !== 8'h00) $display("FAIL async_reset port=%0d got=%h want=00", p, obs(p));
            else passed++;
        end
        bus.we = 1'b1; bus.write_addr = 2'd1; bus.write_data = 8'h77;
        bus.read_addr1 = 2'd1; bus.read_addr2 = 2'd2;
        tick();
        for (int p = 0; p < 4; p++) begin
            checks++;
            if (obs(p) !== 8'h00) $display("FAIL write_in_reset port=%0d got=%h want=00", p, obs(p));
            else passed++;
        end
        @(negedge clk);
        bus.we = 1'b0;
        rst = 1'b0;
        bus.we = 1'b1; bus.write_addr = 2'd1; bus.write_data = 8'h3C;
        #1;
        checks++;
        if (bus.read_data1 !== 8'h00) $display("FAIL post_reset_before got=%h want=00", bus.read_data1);
        else passed++;
        tick();
        bus.we = 1'b0;
        checks++;
        if (bus.read_data1 !== 8'h3C) $display("FAIL first_write_after_reset got=%h want=3c", bus.read_data1);
        else passed++;
        checks++;
        if (bus3.read_data1 !== 8'h3C) $display("FAIL first_write_after_reset_d3 got=%h want=3c", bus3.read_data1);
        else passed++;
    endtask

    task automatic test_sweep();
        data_t want [4];
        @(negedge clk);
        bus.we = 1'b1;
        for (int a = 0; a < 4; a++) begin
            bus.write_addr = addr_t'(a);
            bus.write_data = data_t'(8'h11 * (a + 1));
            tick();
        end
        bus.we = 1'b0;
        for (int a1 = 0; a1 < 4; a1++) begin
            for (int a2 = 0; a2 < 4; a2++) begin
                bus.read_addr1 = addr_t'(a1);
                bus.read_addr2 = addr_t'(a2);
                #1;
                want[0] = data_t'(8'h11 * (a1 + 1));
                want[1] = data_t'(8'h11 * (a2 + 1));
                want[2] = (a1 < 3) ? want[0] : 8'h00;
                want[3] = (a2 < 3) ? want[1] : 8'h00;
                for (int p = 0; p < 4; p++) begin
                    checks++;
                    if (obs(p) !== want[p])
                        $display("FAIL sweep a1=%0d a2=%0d port=%0d got=%h want=%h", a1, a2, p, obs(p), want[p]);
                    else passed++;
                end
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            rst = 1'b0;
            bus.we         = 1'($urandom_range(0, 1));
            bus.write_addr = addr_t'($urandom_range(0, 3));
            bus.write_data = data_t'($urandom);
            bus.read_addr1 = addr_t'($urandom_range(0, 3));
            bus.read_addr2 = addr_t'($urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0) begin
                #1;
                rst = 1'b1;
                model_reset();
            end
            #1;
            for (int p = 0; p < 4; p++) begin
                checks++;
                if (obs(p) !== model_rd(p)) $display("FAIL rand_pre n=%0d port=%0d got=%h want=%h", n, p, obs(p), model_rd(p));
                else passed++;
            end
            tick();
            for (int p = 0; p < 4; p++) begin
                checks++;
                if (obs(p) !== model_rd(p)) $display("FAIL rand_post n=%0d port=%0d got=%h want=%h", n, p, obs(p), model_rd(p));
                else passed++;
            end
        end
        @(negedge clk);
        rst = 1'b0;
        bus.we = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.we = 1'b0;
        bus.write_addr = '0;
        bus.write_data = '0;
        bus.read_addr1 = '0;
        bus.read_addr2 = '0;
        test_reset();
        test_write_read();
        test_we_low();
        test_read_during_write();
        test_async_reset();
        test_sweep();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of each register and of all data ports.
REQ-002 Parameter ADDR_WIDTH, default 2, width of all address ports.
REQ-003 Parameter DEPTH, default 2**ADDR_WIDTH (4), number of registers.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 we  input  1  write enable, sampled on rising clk.
REQ-007 write_addr  input  ADDR_WIDTH  register index to write.
REQ-008 write_data  input  DATA_WIDTH  value to write.
REQ-009 read_addr1  input  ADDR_WIDTH  index for read port 1.
REQ-010 read_addr2  input  ADDR_WIDTH  index for read port 2.
REQ-011 read_data1  output  DATA_WIDTH  contents of register read_addr1.
REQ-012 read_data2  output  DATA_WIDTH  contents of register read_addr2.

Function
REQ-013 Storage SHALL be DEPTH registers of DATA_WIDTH bits each.
REQ-014 On rising clk with we=1 and rst=0, register[write_addr] SHALL load write_data; all other registers SHALL hold.
REQ-015 With we=0, no register SHALL change.
REQ-016 Reads SHALL be combinational: read_dataN = register[read_addrN] with zero clock latency, updating whenever the address or the addressed register changes.
REQ-017 Both read ports SHALL be independent; the same address on both ports SHALL return identical data.
REQ-018 Read-during-write to the same address SHALL return the old value until the rising edge, then the new value (no write-through bypass).
REQ-019 Exactly one register SHALL be written per enabled cycle; write_addr decode SHALL be one-hot.
REQ-020 If DEPTH < 2**ADDR_WIDTH, writes to out-of-range addresses SHALL be ignored and reads from them SHALL return 0.
REQ-021 X/Z on we SHALL not be required to be handled; benches drive only 0/1.

Reset
REQ-022 While rst=1, all registers SHALL be 0 immediately (asynchronous), so read_data1 = read_data2 = 0 for any address.
REQ-023 Writes SHALL be ignored while rst=1, including a rising edge coincident with rst=1.
REQ-024 On rst deassertion, the first write SHALL take effect on the first rising edge with rst=0 and we=1.

Structure
REQ-025 Shared package register_file_pkg SHALL hold DATA_WIDTH/ADDR_WIDTH defaults and a data-word typedef.
REQ-026 One sub-module, register_file_decoder, SHALL convert write_addr plus we into a DEPTH-bit one-hot write-enable vector.
REQ-027 The read path SHALL be a pure multiplexer per port; no clocked read logic.

Verification
REQ-028 Assert rst, then read addresses 0..3 on both ports -> all reads 0.
REQ-029 Release rst; we=1, write_addr=0, write_data=4, one edge; then write_addr=1, write_data=12, one edge; we=0, read_addr1=0, read_addr2=1 -> read_data1=4, read_data2=12.
REQ-030 we=0, write_addr=2, write_data=0xFF, several edges; read register 2 -> still 0, registers 0/1 unchanged (4/12).
REQ-031 Write 0xA5 to register 3 with read_addr1=read_addr2=3 -> both ports show old value 0 before the edge and 0xA5 immediately after it.
REQ-032 Write 0x5A to register 2, then assert rst asynchronously mid-cycle -> all reads drop to 0 before the next edge; a we=1 edge during rst leaves registers at 0.
REQ-033 Write distinct values 0x11/0x22/0x33/0x44 to registers 0..3, sweep both read ports over all address pairs -> each port returns its addressed value.
